// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the three requester ports, the shared downstream port and arbiter status.
// Handshake: toggle protocol; port i has a request outstanding while req_i != ack_i. Its addr/wr/be/din stay stable until ack_i catches up.
interface sdram_port_arbiter_if #(parameter int AW = 24);
    logic [AW-1:0] addr0, addr1, addr2;
    logic          req0, req1, req2;
    logic          wr0, wr1, wr2;
    logic [1:0]    be0, be1, be2;
    logic [15:0]   din0, din1, din2;
    logic          ack0, ack1, ack2;
    logic [15:0]   dout0, dout1, dout2;

    logic [AW-1:0] m_addr;
    logic          m_req;
    logic          m_wr;
    logic [1:0]    m_be;
    logic [15:0]   m_din;
    logic          m_ack;
    logic [15:0]   m_dout;

    logic          busy;
    logic [1:0]    grant;
    logic          state_dbg;
    logic [7:0]    starve_dbg;

    modport slave (
        input  addr0, addr1, addr2, req0, req1, req2, wr0, wr1, wr2,
        input  be0, be1, be2, din0, din1, din2,
        output ack0, ack1, ack2, dout0, dout1, dout2,
        output m_addr, m_req, m_wr, m_be, m_din,
        input  m_ack, m_dout,
        output busy, grant, state_dbg, starve_dbg
    );

    modport master (
        output addr0, addr1, addr2, req0, req1, req2, wr0, wr1, wr2,
        output be0, be1, be2, din0, din1, din2,
        input  ack0, ack1, ack2, dout0, dout1, dout2,
        input  m_addr, m_req, m_wr, m_be, m_din,
        output m_ack, m_dout,
        input  busy, grant, state_dbg, starve_dbg
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Three-to-one arbiter for a toggle-handshake SDRAM port: port 0 has priority,
// ports 1/2 alternate, and a starvation guard occasionally skips port 0.
module sdram_port_arbiter #(
    parameter int AW         = 24,
    parameter int STARVE_MAX = 8
) (
    input logic              clk,
    input logic              resetn,
    sdram_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t        state;
    logic          rr_is2;
    logic [7:0]    starve_cnt;
    logic [2:0]    pend;
    logic          starved;
    logic [1:0]    win;
    logic [AW-1:0] sel_addr;
    logic          sel_wr;
    logic [1:0]    sel_be;
    logic [15:0]   sel_din;

    assign pend    = {bus.req2 ^ bus.ack2, bus.req1 ^ bus.ack1, bus.req0 ^ bus.ack0};
    assign starved = (starve_cnt == 8'(STARVE_MAX)) && (pend[1] || pend[2]);

    assign bus.state_dbg  = (state == WAIT);
    assign bus.starve_dbg = starve_cnt;

    always_comb begin
        win = 2'd0;
        if (pend[0] && !starved) begin
            win = 2'd0;
        end else if (rr_is2) begin
            win = pend[2] ? 2'd2 : 2'd1;
        end else begin
            win = pend[1] ? 2'd1 : 2'd2;
        end
    end

    always_comb begin
        sel_addr = bus.addr0;
        sel_wr   = bus.wr0;
        sel_be   = bus.be0;
        sel_din  = bus.din0;
        case (win)
            2'd1: begin
                sel_addr = bus.addr1;
                sel_wr   = bus.wr1;
                sel_be   = bus.be1;
                sel_din  = bus.din1;
            end
            2'd2: begin
                sel_addr = bus.addr2;
                sel_wr   = bus.wr2;
                sel_be   = bus.be2;
                sel_din  = bus.din2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            rr_is2     <= 1'b0;
            starve_cnt <= 8'd0;
            bus.ack0   <= 1'b0;
            bus.ack1   <= 1'b0;
            bus.ack2   <= 1'b0;
            bus.dout0  <= 16'd0;
            bus.dout1  <= 16'd0;
            bus.dout2  <= 16'd0;
            bus.m_addr <= '0;
            bus.m_req  <= 1'b0;
            bus.m_wr   <= 1'b0;
            bus.m_be   <= 2'd0;
            bus.m_din  <= 16'd0;
            bus.busy   <= 1'b0;
            bus.grant  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pend) begin
                        bus.m_addr <= sel_addr;
                        bus.m_wr   <= sel_wr;
                        bus.m_be   <= sel_be;
                        bus.m_din  <= sel_din;
                        bus.m_req  <= ~bus.m_req;
                        bus.grant  <= win;
                        bus.busy   <= 1'b1;
                        state      <= WAIT;
                        if (win == 2'd0) begin
                            // Only count port-0 wins that actually held someone else off.
                            if (pend[1] || pend[2]) begin
                                if (starve_cnt != 8'(STARVE_MAX))
                                    starve_cnt <= starve_cnt + 8'd1;
                            end else begin
                                starve_cnt <= 8'd0;
                            end
                        end else begin
                            starve_cnt <= 8'd0;
                            rr_is2     <= (win == 2'd1);
                        end
                    end
                end
                WAIT: begin
                    if (bus.m_ack == bus.m_req) begin
                        case (bus.grant)
                            2'd0: begin
                                bus.ack0 <= ~bus.ack0;
                                if (!bus.m_wr) bus.dout0 <= bus.m_dout;
                            end
                            2'd1: begin
                                bus.ack1 <= ~bus.ack1;
                                if (!bus.m_wr) bus.dout1 <= bus.m_dout;
                            end
                            2'd2: begin
                                bus.ack2 <= ~bus.ack2;
                                if (!bus.m_wr) bus.dout2 <= bus.m_dout;
                            end
                            default: ;
                        endcase
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: downstream responder model, grant-order
// scoreboard, table of single transactions and hand-written multi-cycle sequences.
module tb_sdram_port_arbiter;
    localparam int AW  = 24;
    localparam int SBW = 2 + AW;

    logic clk;
    logic resetn;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   ds_lat = 1;
    logic [15:0] ds_data = 16'h0;
    int   ds_ack_cyc = 0;
    int   last_req_cyc = 0;
    int   req_gap = 0;
    logic [SBW-1:0] exp_q[$];

    typedef struct {
        int          port;
        logic        wr;
        logic [1:0]  be;
        logic [23:0] addr;
        logic [15:0] din;
        logic [15:0] rdata;
        int          lat;
    } vec_t;

    vec_t        vecs[8];
    logic [15:0] dout_model[3];

    sdram_port_arbiter_if #(.AW(AW)) bus ();

    sdram_port_arbiter #(.AW(AW), .STARVE_MAX(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input int p, input logic [AW-1:0] a, input logic w,
                         input logic [1:0] b, input logic [15:0] d);
        case (p)
            0: begin bus.addr0 = a; bus.wr0 = w; bus.be0 = b; bus.din0 = d; bus.req0 = ~bus.req0; end
            1: begin bus.addr1 = a; bus.wr1 = w; bus.be1 = b; bus.din1 = d; bus.req1 = ~bus.req1; end
            default: begin bus.addr2 = a; bus.wr2 = w; bus.be2 = b; bus.din2 = d; bus.req2 = ~bus.req2; end
        endcase
    endtask

    function automatic logic all_idle();
        return (bus.req0 == bus.ack0) && (bus.req1 == bus.ack1) &&
               (bus.req2 == bus.ack2) && !bus.busy;
    endfunction

    function automatic logic [15:0] get_dout(input int p);
        case (p)
            0:       return bus.dout0;
            1:       return bus.dout1;
            default: return bus.dout2;
        endcase
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!all_idle() && n < budget);
        check({name, "_done"}, 32'(all_idle()), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},   32'({bus.ack2, bus.ack1, bus.ack0}), 32'd0);
        check({tag, "_dout0"}, 32'(bus.dout0), 32'd0);
        check({tag, "_dout1"}, 32'(bus.dout1), 32'd0);
        check({tag, "_dout2"}, 32'(bus.dout2), 32'd0);
        check({tag, "_m_addr"}, 32'(bus.m_addr), 32'd0);
        check({tag, "_m_ctl"}, 32'({bus.m_req, bus.m_wr, bus.m_be}), 32'd0);
        check({tag, "_m_din"}, 32'(bus.m_din), 32'd0);
        check({tag, "_busy_grant"}, 32'({bus.busy, bus.grant}), 32'd0);
        check({tag, "_state_starve"}, 32'({bus.state_dbg, bus.starve_dbg}), 32'd0);
    endtask

    // Downstream controller: answers ds_lat edges after it first sees a request.
    initial begin
        int cnt = 0;
        bus.m_ack  = 1'b0;
        bus.m_dout = 16'h0;
        forever begin
            @(posedge clk); #1;
            if (!resetn) begin
                cnt = 0;
                bus.m_ack  = 1'b0;
                bus.m_dout = 16'h0;
            end else if (bus.m_req != bus.m_ack) begin
                cnt++;
                if (cnt > ds_lat) begin
                    bus.m_dout = ds_data;
                    bus.m_ack  = bus.m_req;
                    ds_ack_cyc = cyc;
                    cnt = 0;
                end
            end
        end
    end

    // Grant-order scoreboard: every downstream issue must match the next expected {port, addr}.
    initial begin
        logic prev_req = 1'b0;
        logic [SBW-1:0] e;
        forever begin
            @(posedge clk); #1;
            if (!resetn) begin
                prev_req = bus.m_req;
            end else if (bus.m_req != prev_req) begin
                prev_req     = bus.m_req;
                req_gap      = cyc - last_req_cyc;
                last_req_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected_issue: got grant %0d addr 0x%0h, expected nothing", bus.grant, bus.m_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_grant_addr", 32'({bus.grant, bus.m_addr}), 32'(e));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   busy_n, k_ack, ack_cyc, acks0, rereq, stale;
        logic prev_ack0, prev_ack2;
        logic [7:0] starve_at_p1;
        logic [15:0] exp_dout;

        vecs[0] = '{1, 1'b0, 2'b11, 24'h000010, 16'h0000, 16'h1234, 2};
        vecs[1] = '{1, 1'b1, 2'b01, 24'h000011, 16'h00AA, 16'hDEAD, 1};
        vecs[2] = '{0, 1'b0, 2'b11, 24'hFFFFFF, 16'h0000, 16'hA5A5, 0};
        vecs[3] = '{0, 1'b1, 2'b11, 24'h000000, 16'hFFFF, 16'h1111, 3};
        vecs[4] = '{2, 1'b0, 2'b11, 24'h000100, 16'h0000, 16'h0001, 5};
        vecs[5] = '{2, 1'b1, 2'b10, 24'h800000, 16'h5500, 16'h2222, 1};
        vecs[6] = '{2, 1'b0, 2'b11, 24'h7FFFFF, 16'h0000, 16'hFFFF, 1};
        vecs[7] = '{1, 1'b0, 2'b11, 24'h123456, 16'h0000, 16'h0000, 2};
        for (int i = 0; i < 3; i++) dout_model[i] = 16'h0;

        resetn = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.req2 = 0;
        bus.wr0 = 0; bus.wr1 = 0; bus.wr2 = 0;
        bus.be0 = 0; bus.be1 = 0; bus.be2 = 0;
        bus.din0 = 0; bus.din1 = 0; bus.din2 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.addr2 = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        @(posedge clk); #3;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Single read from port 2, three-cycle downstream latency
        ds_lat = 3; ds_data = 16'hBEEF;
        exp_q.push_back({2'd2, 24'h000100});
        issue(2, 24'h000100, 1'b0, 2'b11, 16'h0);
        busy_n = 0; k_ack = 0; ack_cyc = 0; prev_ack2 = bus.ack2;
        for (int k = 1; k <= 20 && k_ack == 0; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                check("t1_m_addr", 32'(bus.m_addr), 32'h100);
                check("t1_grant", 32'(bus.grant), 32'd2);
                check("t1_busy_on", 32'(bus.busy), 32'd1);
            end
            if (bus.busy) busy_n++;
            if (bus.ack2 != prev_ack2) begin
                k_ack = k;
                ack_cyc = cyc;
            end
        end
        check("t1_ack_latency", 32'(k_ack), 32'd5);
        check("t1_busy_cycles", 32'(busy_n), 32'd4);
        check("t1_ack_after_mack", 32'(ack_cyc - ds_ack_cyc), 32'd1);
        check("t1_dout2", 32'(bus.dout2), 32'hBEEF);
        dout_model[2] = 16'hBEEF;

        // Simultaneous 0+1+2, then a lone port 1 to move the pointer, then 1+2
        ds_lat = 2; ds_data = 16'h0F0F;
        exp_q.push_back({2'd0, 24'h000A00});
        exp_q.push_back({2'd1, 24'h000B00});
        exp_q.push_back({2'd2, 24'h000C00});
        issue(0, 24'h000A00, 1'b0, 2'b11, 16'h0);
        issue(1, 24'h000B00, 1'b0, 2'b11, 16'h0);
        issue(2, 24'h000C00, 1'b0, 2'b11, 16'h0);
        wait_done("t2_burst3", 80);
        exp_q.push_back({2'd1, 24'h000B01});
        issue(1, 24'h000B01, 1'b0, 2'b11, 16'h0);
        wait_done("t2_lone1", 40);
        exp_q.push_back({2'd2, 24'h000C02});
        exp_q.push_back({2'd1, 24'h000B02});
        issue(1, 24'h000B02, 1'b0, 2'b11, 16'h0);
        issue(2, 24'h000C02, 1'b0, 2'b11, 16'h0);
        wait_done("t2_burst12", 60);

        // Starvation guard: port 0 re-requests right after every ack while port 1 waits
        ds_lat = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back({2'd0, 24'h000A10});
        exp_q.push_back({2'd1, 24'h000B10});
        exp_q.push_back({2'd0, 24'h000A10});
        issue(0, 24'h000A10, 1'b0, 2'b11, 16'h0);
        issue(1, 24'h000B10, 1'b0, 2'b11, 16'h0);
        acks0 = 0; rereq = 0; starve_at_p1 = 8'hFF; prev_ack0 = bus.ack0;
        for (int n = 0; n < 300 && !(acks0 == 9 && all_idle()); n++) begin
            @(posedge clk); #1;
            if (bus.ack0 != prev_ack0) begin
                prev_ack0 = bus.ack0;
                acks0++;
                if (rereq < 8) begin
                    issue(0, 24'h000A10, 1'b0, 2'b11, 16'h0);
                    rereq++;
                end
            end
            if (bus.busy && bus.grant == 2'd1 && starve_at_p1 == 8'hFF) starve_at_p1 = bus.starve_dbg;
        end
        check("t3_port0_acks", 32'(acks0), 32'd9);
        check("t3_starve_at_p1", 32'(starve_at_p1), 32'd0);
        check("t3_starve_end", 32'(bus.starve_dbg), 32'd0);

        // Back-to-back with one-cycle downstream: issues three edges apart
        ds_lat = 1;
        exp_q.push_back({2'd2, 24'h000C20});
        exp_q.push_back({2'd1, 24'h000B20});
        issue(1, 24'h000B20, 1'b0, 2'b11, 16'h0);
        issue(2, 24'h000C20, 1'b0, 2'b11, 16'h0);
        wait_done("t4_b2b", 40);
        check("t4_issue_gap", 32'(req_gap), 32'd3);

        // Table of single transactions
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            ds_lat = v.lat; ds_data = v.rdata;
            exp_dout = v.wr ? dout_model[v.port] : v.rdata;
            dout_model[v.port] = exp_dout;
            exp_q.push_back({2'(v.port), v.addr});
            issue(v.port, v.addr, v.wr, v.be, v.din);
            wait_done($sformatf("v%0d", i), 40);
            check($sformatf("v%0d_grant", i), 32'(bus.grant), 32'(v.port));
            check($sformatf("v%0d_m_addr", i), 32'(bus.m_addr), 32'(v.addr));
            check($sformatf("v%0d_m_wr_be", i), 32'({bus.m_wr, bus.m_be}), 32'({v.wr, v.be}));
            check($sformatf("v%0d_m_din", i), 32'(bus.m_din), 32'(v.din));
            check($sformatf("v%0d_dout", i), 32'(get_dout(v.port)), 32'(exp_dout));
        end

        // Reset while port 0 is waiting on the downstream
        ds_lat = 20;
        exp_q.push_back({2'd0, 24'h00C000});
        issue(0, 24'h00C000, 1'b0, 2'b11, 16'h0);
        repeat (3) begin @(posedge clk); #1; end
        check("t6_in_wait", 32'({bus.state_dbg, bus.busy}), 32'b11);
        #2;
        resetn = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.req2 = 0;
        #1;
        check_all_zero("t6_rst");
        repeat (3) @(posedge clk);
        #3;
        resetn = 1'b1;
        @(posedge clk); #1;
        ds_lat = 2; ds_data = 16'h3C3C;
        exp_q.push_back({2'd2, 24'h000042});
        issue(2, 24'h000042, 1'b0, 2'b11, 16'h0);
        stale = 0;
        for (int n = 0; n < 30 && bus.ack2 != 1'b1; n++) begin
            @(posedge clk); #1;
            if (bus.ack0 != 1'b0) stale = 1;
        end
        check("t6_ack2", 32'(bus.ack2), 32'd1);
        check("t6_dout2", 32'(bus.dout2), 32'h3C3C);
        check("t6_no_stale_ack0", 32'(stale), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("t6_ack0_quiet", 32'(bus.ack0), 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
